mac_arbiter: RTL and testbench
==============================

# mac_arbiter

Round-robin arbiter and sequencer that shares a single `mac` engine among `NCH` requesting channels. Each granted request configures the MAC with that channel's tap count and shift, launches it with a one-cycle start pulse, and prefixes the MAC coefficient/sample index with the channel number to form the ROM address. On completion it returns the 18-bit result to the owning channel. A watchdog aborts a run that never signals end-of-filter. Sits between the channel filter front-ends and the shared `mac` + `rom_x`/`rom_a` datapath.

## Interface
Parameters:
- `NCH`, 4: number of requesting channels (2..8).
- `CW`, 2: channel index width, equal to clog2(`NCH`).
- `TIMEOUT`, 255: maximum cycles in RUN before abort (1..65535).

Ports:
- `clk_i` in 1: single clock, all logic on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low. The MAC reset is driven as ~`rst_ni` at top level.
- `req_i` in `NCH`: level request per channel, held until that channel's `done_o` bit.
- `n_i` in 6*`NCH`: tap count for channel k at [6k+5:6k].
- `s_i` in 6*`NCH`: result shift for channel k at [6k+5:6k].
- `done_o` out `NCH`: one-hot, one-cycle completion pulse.
- `err_o` out 1: qualifies `done_o`; 1 means aborted or rejected.
- `y_o` out 18: result, valid with `done_o`, held until the next `done_o`.
- `busy_o` out 1: high in every state except IDLE.
- `gnt_o` out `CW`: channel currently or last served.
- `mac_stf_o` out 1: MAC start pulse.
- `mac_n_o` out 6: tap count to the MAC, registered.
- `mac_s_o` out 6: shift to the MAC, registered.
- `mac_y_i` in 18: MAC result.
- `mac_i_i` in 6: MAC index.
- `mac_eof_i` in 1: MAC end-of-filter, a one-cycle pulse.
- `addr_o` out `CW`+6: ROM address, {`gnt_o`, `mac_i_i`}, combinational.

## Operation
- FSM states: IDLE, LAUNCH, RUN, DONE.
- IDLE: search `req_i` starting at `ptr` and wrapping modulo `NCH`; the first set bit wins. Register `gnt_o`, `mac_n_o`, `mac_s_o` from the winner.
  - Winner's n = 0: go to DONE with `err_o`=1 and `y_o`=0. The MAC is not started.
  - Otherwise go to LAUNCH.
- `ptr` updates to (winner+1) mod `NCH` on every grant, including rejects.
- LAUNCH: `mac_stf_o`=1 for exactly this cycle. Clear the watchdog and go to RUN.
- RUN: the watchdog increments each cycle.
  - `mac_eof_i`=1: capture `mac_y_i` and go to DONE (err=0).
  - Watchdog reaches `TIMEOUT`: set `y_o`=0 and go to DONE (err=1).
  - If eof and timeout occur in the same cycle, eof wins.
- DONE: `done_o[gnt_o]`=1 for one cycle, then go to IDLE.
- `mac_eof_i` outside RUN is ignored.
- `req_i` deasserting after grant does not cancel the run; `done_o` still pulses.
- A requester re-asserting immediately is re-eligible; round-robin guarantees the others are served first.
- `n_i`/`s_i` changes after grant have no effect on the run in progress.

## Timing
- Request seen in IDLE at cycle t: `mac_stf_o` high at t+1 (LAUNCH); RUN from t+2.
- eof at cycle e: `done_o`/`y_o`/`err_o` at e+1; IDLE at e+2.
- Earliest next `mac_stf_o` is e+3.
- Reject path: request at t gives `done_o` with err at t+1.
- Timeout: `done_o` with err at t+2+`TIMEOUT`.
- Reset (asynchronous, any state): state IDLE, `ptr`=0, watchdog 0, all outputs 0.
  - `mac_stf_o`, `done_o`, `err_o`, `busy_o`, `y_o`, `gnt_o`, `mac_n_o`, `mac_s_o` are all 0.
  - A run in progress is dropped with no `done_o`.
- First grant after reset release is the lowest set `req_i` bit.

## Test plan
- Single request: `req_i`=0001, n=5, s=28, MAC model pulses eof 7 cycles after stf with y=0x1234 -> one `mac_stf_o` pulse, `addr_o` upper bits 0, `done_o`=0001, `y_o`=0x1234, `err_o`=0 at eof+1.
- Fairness: `req_i`=1111 held, requesters drop on their done -> grant order 0,1,2,3. Re-assert all -> order 0,1,2,3 again, since `ptr` wraps to 0.
- Starvation: channel 0 re-requests immediately every time, channel 2 held -> grants alternate 0,2,0,2 (channel 2 never waits more than one run).
- n=0 on channel 1 -> no `mac_stf_o`, `done_o`=0010, `err_o`=1, `y_o`=0 one cycle after request.
- Timeout: `TIMEOUT`=10, MAC never pulses eof -> `done_o` with `err_o`=1 exactly 12 cycles after grant. A late eof afterwards is ignored; the next request proceeds normally.
- Reset mid-RUN: `rst_ni` low at RUN+3 -> all outputs 0 immediately, no `done_o` ever issued for that run. After release, a pending `req_i`=0100 is granted at the first IDLE cycle.

Source files
------------

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin sequencer sharing one MAC among NCH channels,
// with per-run configuration, start pulse, result return and a watchdog.
module mac_arbiter #(
    parameter int NCH     = 4,
    parameter int CW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NCH-1:0]    req_i,
    input  logic [6*NCH-1:0]  n_i,
    input  logic [6*NCH-1:0]  s_i,
    output logic [NCH-1:0]    done_o,
    output logic              err_o,
    output logic [17:0]       y_o,
    output logic              busy_o,
    output logic [CW-1:0]     gnt_o,
    output logic              mac_stf_o,
    output logic [5:0]        mac_n_o,
    output logic [5:0]        mac_s_o,
    input  logic [17:0]       mac_y_i,
    input  logic [5:0]        mac_i_i,
    input  logic              mac_eof_i,
    output logic [CW+5:0]     addr_o
);
    localparam int W = CW + 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_ptr, r_gnt;
    logic [5:0]      r_n, r_s;
    logic [17:0]     r_y;
    logic            r_err;
    logic [15:0]     r_wd;
    logic [NCH-1:0]  w_rot;
    logic [W-1:0]    w_off, w_sum;
    logic [CW-1:0]   w_win, w_ptr_nxt;
    logic [5:0]      w_n, w_s;
    logic            w_req, w_to;

    // Rotate requests so bit 0 is the channel at ptr; lowest set bit wins.
    assign w_rot = NCH'({req_i, req_i} >> r_ptr);
    assign w_req = |req_i;

    always_comb begin
        w_off = '0;
        for (int j = NCH - 1; j >= 0; j--)
            if (w_rot[j]) w_off = W'(j);
    end

    assign w_sum     = W'(r_ptr) + w_off;
    assign w_win     = (w_sum >= W'(NCH)) ? CW'(w_sum - W'(NCH)) : w_sum[CW-1:0];
    assign w_ptr_nxt = (w_win == CW'(NCH - 1)) ? '0 : w_win + CW'(1);

    always_comb begin
        w_n = '0;
        w_s = '0;
        for (int k = 0; k < NCH; k++)
            if (w_win == CW'(k)) begin
                w_n = n_i[6*k +: 6];
                w_s = s_i[6*k +: 6];
            end
    end

    assign w_to = (r_wd == WD_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = (w_n == 6'd0) ? DONE : LAUNCH;
            LAUNCH:  w_state_nxt = RUN;
            RUN:     if (mac_eof_i || w_to) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_n   <= '0;
            r_s   <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
            r_wd  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_gnt <= w_win;
                    r_n   <= w_n;
                    r_s   <= w_s;
                    r_ptr <= w_ptr_nxt;
                    if (w_n == 6'd0) begin
                        r_y   <= '0;
                        r_err <= 1'b1;
                    end
                end
                LAUNCH: r_wd <= '0;
                RUN: begin
                    r_wd <= r_wd + 16'd1;
                    // eof takes priority over a simultaneous timeout
                    if (mac_eof_i) begin
                        r_y   <= mac_y_i;
                        r_err <= 1'b0;
                    end else if (w_to) begin
                        r_y   <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o    = (r_state == DONE) ? (NCH'(1) << r_gnt) : '0;
    assign err_o     = r_err;
    assign y_o       = r_y;
    assign busy_o    = (r_state != IDLE);
    assign gnt_o     = r_gnt;
    assign mac_stf_o = (r_state == LAUNCH);
    assign mac_n_o   = r_n;
    assign mac_s_o   = r_s;
    assign addr_o    = {r_gnt, mac_i_i};
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed and randomized checks of mac_arbiter against a
// round-robin / timing reference model.
module tb_mac_arbiter;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int T   = 10;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NCH-1:0]    req_i;
    logic [6*NCH-1:0]  n_i, s_i;
    logic [NCH-1:0]    done_o;
    logic              err_o;
    logic [17:0]       y_o;
    logic              busy_o;
    logic [CW-1:0]     gnt_o;
    logic              mac_stf_o;
    logic [5:0]        mac_n_o, mac_s_o;
    logic [17:0]       mac_y_i;
    logic [5:0]        mac_i_i;
    logic              mac_eof_i;
    logic [CW+5:0]     addr_o;

    int n_tests = 0;
    int n_fail  = 0;
    int mptr;
    int nv[NCH];
    int sv[NCH];

    mac_arbiter #(.NCH(NCH), .CW(CW), .TIMEOUT(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .n_i(n_i), .s_i(s_i),
        .done_o(done_o), .err_o(err_o), .y_o(y_o), .busy_o(busy_o), .gnt_o(gnt_o),
        .mac_stf_o(mac_stf_o), .mac_n_o(mac_n_o), .mac_s_o(mac_s_o),
        .mac_y_i(mac_y_i), .mac_i_i(mac_i_i), .mac_eof_i(mac_eof_i), .addr_o(addr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_cfg;
        for (int k = 0; k < NCH; k++) begin
            n_i[6*k +: 6] = 6'(nv[k]);
            s_i[6*k +: 6] = 6'(sv[k]);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] req, input int ptr);
        for (int off = 0; off < NCH; off++)
            if (req[(ptr + off) % NCH]) return (ptr + off) % NCH;
        return -1;
    endfunction

    task automatic do_reset;
        rst_ni = 1'b0;
        req_i = '0;
        mac_eof_i = 1'b0;
        tick;
        tick;
        rst_ni = 1'b1;
        mptr = 0;
    endtask

    task automatic test_reset;
        req_i = '0; mac_eof_i = 1'b0; mac_y_i = '0; mac_i_i = '0;
        for (int k = 0; k < NCH; k++) begin nv[k] = 3; sv[k] = 1; end
        drive_cfg;
        rst_ni = 1'b0;
        #1;
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        n_tests++; if (done_o !== '0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_o); end
        n_tests++; if ({err_o, y_o, gnt_o, mac_stf_o, mac_n_o, mac_s_o} !== '0)
            begin n_fail++; $display("FAIL reset_outs got=%h want=0", {err_o, y_o, gnt_o, mac_stf_o, mac_n_o, mac_s_o}); end
        tick;
        rst_ni = 1'b1;
        mptr = 0;
        tick;
    endtask

    task automatic test_single;
        nv[0] = 5; sv[0] = 28; drive_cfg;
        mac_i_i = 6'h15;
        req_i = 4'b0001;
        tick;
        n_tests++; if (mac_stf_o !== 1'b1) begin n_fail++; $display("FAIL single_stf got=%b want=1", mac_stf_o); end
        n_tests++; if (addr_o !== 8'h15) begin n_fail++; $display("FAIL single_addr got=%h want=15", addr_o); end
        n_tests++; if (mac_n_o !== 6'd5 || mac_s_o !== 6'd28)
            begin n_fail++; $display("FAIL single_cfg got=%0d/%0d want=5/28", mac_n_o, mac_s_o); end
        for (int k = 0; k < 7; k++) begin
            tick;
            n_tests++; if (mac_stf_o !== 1'b0) begin n_fail++; $display("FAIL single_stf_once got=%b want=0", mac_stf_o); end
        end
        mac_eof_i = 1'b1; mac_y_i = 18'h1234;
        tick;
        mac_eof_i = 1'b0; mac_y_i = '0;
        n_tests++; if (done_o !== 4'b0001) begin n_fail++; $display("FAIL single_done got=%b want=0001", done_o); end
        n_tests++; if (y_o !== 18'h1234 || err_o !== 1'b0)
            begin n_fail++; $display("FAIL single_y got=%h/%b want=1234/0", y_o, err_o); end
        req_i = '0;
        tick;
        n_tests++; if (busy_o !== 1'b0 || done_o !== '0)
            begin n_fail++; $display("FAIL single_idle got=%b/%b want=0/0", busy_o, done_o); end
        n_tests++; if (y_o !== 18'h1234) begin n_fail++; $display("FAIL single_hold got=%h want=1234", y_o); end
        mptr = 1;
    endtask

    task automatic test_fairness;
        logic [NCH-1:0] pend;
        do_reset;
        for (int k = 0; k < NCH; k++) nv[k] = 2;
        drive_cfg;
        pend = 4'b1111;
        req_i = pend;
        for (int i = 0; i < 2 * NCH; i++) begin
            tick;
            n_tests++; if (mac_stf_o !== 1'b1 || gnt_o !== CW'(i % NCH))
                begin n_fail++; $display("FAIL fair_gnt got=%0d want=%0d", gnt_o, i % NCH); end
            tick;
            tick;
            mac_eof_i = 1'b1; mac_y_i = 18'(i);
            tick;
            mac_eof_i = 1'b0;
            n_tests++; if (done_o !== NCH'(1) << (i % NCH))
                begin n_fail++; $display("FAIL fair_done got=%b want=%0d", done_o, i % NCH); end
            pend[i % NCH] = 1'b0;
            req_i = pend;
            tick;
            if (pend == '0) pend = 4'b1111;
            req_i = pend;
        end
        req_i = '0;
        tick;
        mptr = 0;
    endtask

    task automatic test_starvation;
        int exp_ch;
        do_reset;
        nv[0] = 3; nv[2] = 3; drive_cfg;
        req_i = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 0) ? 0 : 2;
            tick;
            n_tests++; if (gnt_o !== CW'(exp_ch) || mac_stf_o !== 1'b1)
                begin n_fail++; $display("FAIL starve_gnt got=%0d want=%0d", gnt_o, exp_ch); end
            tick;
            mac_eof_i = 1'b1;
            tick;
            mac_eof_i = 1'b0;
            n_tests++; if (done_o !== NCH'(1) << exp_ch)
                begin n_fail++; $display("FAIL starve_done got=%b want=%0d", done_o, exp_ch); end
            tick;
        end
        req_i = '0;
        tick;
        mptr = 3;
    endtask

    task automatic test_reject;
        nv[1] = 0; drive_cfg;
        req_i = 4'b0010;
        tick;
        n_tests++; if (done_o !== 4'b0010 || err_o !== 1'b1 || y_o !== '0)
            begin n_fail++; $display("FAIL reject got=%b/%b/%h want=0010/1/0", done_o, err_o, y_o); end
        n_tests++; if (mac_stf_o !== 1'b0) begin n_fail++; $display("FAIL reject_stf got=%b want=0", mac_stf_o); end
        req_i = '0;
        tick;
        n_tests++; if (busy_o !== 1'b0 || mac_stf_o !== 1'b0)
            begin n_fail++; $display("FAIL reject_idle got=%b/%b want=0/0", busy_o, mac_stf_o); end
        mptr = 2;
    endtask

    task automatic test_timeout;
        int cnt;
        nv[3] = 4; nv[0] = 3; drive_cfg;
        req_i = 4'b1000;
        cnt = 0;
        do begin
            tick;
            cnt++;
        end while (done_o == '0 && cnt < 40);
        n_tests++; if (cnt !== T + 2) begin n_fail++; $display("FAIL timeout_cycles got=%0d want=%0d", cnt, T + 2); end
        n_tests++; if (done_o !== 4'b1000 || err_o !== 1'b1 || y_o !== '0)
            begin n_fail++; $display("FAIL timeout_done got=%b/%b/%h want=1000/1/0", done_o, err_o, y_o); end
        req_i = '0;
        tick;
        mac_eof_i = 1'b1; mac_y_i = 18'h3ffff;
        req_i = 4'b0001;
        tick;
        n_tests++; if (mac_stf_o !== 1'b1 || done_o !== '0 || gnt_o !== 2'd0)
            begin n_fail++; $display("FAIL late_eof got=%b/%b/%0d want=1/0/0", mac_stf_o, done_o, gnt_o); end
        tick;
        mac_eof_i = 1'b0;
        n_tests++; if (done_o !== '0) begin n_fail++; $display("FAIL late_eof_run got=%b want=0", done_o); end
        mac_eof_i = 1'b1; mac_y_i = 18'h2a;
        tick;
        mac_eof_i = 1'b0;
        n_tests++; if (done_o !== 4'b0001 || err_o !== 1'b0 || y_o !== 18'h2a)
            begin n_fail++; $display("FAIL after_timeout got=%b/%b/%h want=0001/0/2a", done_o, err_o, y_o); end
        req_i = '0;
        tick;
        mptr = 1;
    endtask

    task automatic test_reset_midrun;
        nv[0] = 7; nv[2] = 4; drive_cfg;
        req_i = 4'b0001;
        for (int k = 0; k < 5; k++) tick;
        rst_ni = 1'b0;
        #1;
        n_tests++; if ({busy_o, mac_stf_o, gnt_o, mac_n_o, mac_s_o, done_o, err_o, y_o} !== '0)
            begin n_fail++; $display("FAIL midrun_reset got=%h want=0", {busy_o, mac_stf_o, gnt_o, mac_n_o, mac_s_o, done_o, err_o, y_o}); end
        req_i = 4'b0100;
        tick;
        tick;
        n_tests++; if (done_o !== '0) begin n_fail++; $display("FAIL midrun_nodone got=%b want=0", done_o); end
        rst_ni = 1'b1;
        tick;
        n_tests++; if (mac_stf_o !== 1'b1 || gnt_o !== 2'd2)
            begin n_fail++; $display("FAIL midrun_regrant got=%b/%0d want=1/2", mac_stf_o, gnt_o); end
        tick;
        mac_eof_i = 1'b1; mac_y_i = 18'h00777;
        tick;
        mac_eof_i = 1'b0;
        n_tests++; if (done_o !== 4'b0100 || y_o !== 18'h00777)
            begin n_fail++; $display("FAIL midrun_done got=%b/%h want=0100/777", done_o, y_o); end
        req_i = '0;
        tick;
        mptr = 3;
    endtask

    task automatic test_random;
        logic [NCH-1:0] pend;
        int w, r, en, es;
        logic [17:0] yv, ey;
        logic ee;
        pend = '0;
        for (int it = 0; it < 60; it++) begin
            pend = pend | NCH'($urandom);
            if (pend == '0) pend[$urandom_range(0, NCH - 1)] = 1'b1;
            for (int k = 0; k < NCH; k++) begin
                nv[k] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 63);
                sv[k] = $urandom_range(0, 63);
            end
            drive_cfg;
            req_i = pend;
            w = rr_pick(pend, mptr);
            mptr = (w + 1) % NCH;
            en = nv[w]; es = sv[w];
            tick;
            n_tests++; if (gnt_o !== CW'(w)) begin n_fail++; $display("FAIL rnd_gnt got=%0d want=%0d", gnt_o, w); end
            if (en == 0) begin
                ee = 1'b1; ey = '0;
                n_tests++; if (mac_stf_o !== 1'b0) begin n_fail++; $display("FAIL rnd_rej_stf got=%b want=0", mac_stf_o); end
            end else begin
                n_tests++; if (mac_stf_o !== 1'b1 || mac_n_o !== 6'(en) || mac_s_o !== 6'(es))
                    begin n_fail++; $display("FAIL rnd_launch got=%b/%0d/%0d want=1/%0d/%0d", mac_stf_o, mac_n_o, mac_s_o, en, es); end
                for (int k = 0; k < NCH; k++) begin nv[k] = $urandom_range(0, 63); sv[k] = $urandom_range(0, 63); end
                drive_cfg;
                r = $urandom_range(0, T + 1);
                yv = 18'($urandom);
                ee = (r >= T);
                ey = ee ? 18'h0 : yv;
                tick;
                for (int k = 0; k < T; k++) begin
                    n_tests++; if (done_o !== '0) begin n_fail++; $display("FAIL rnd_early_done got=%b want=0", done_o); end
                    if (k == r) begin
                        mac_eof_i = 1'b1; mac_y_i = yv;
                        tick;
                        mac_eof_i = 1'b0;
                        break;
                    end
                    tick;
                end
            end
            n_tests++; if (done_o !== NCH'(1) << w || err_o !== ee || y_o !== ey)
                begin n_fail++; $display("FAIL rnd_done got=%b/%b/%h want=%0d/%b/%h", done_o, err_o, y_o, w, ee, ey); end
            n_tests++; if (mac_n_o !== 6'(en)) begin n_fail++; $display("FAIL rnd_cfg_held got=%0d want=%0d", mac_n_o, en); end
            pend[w] = 1'b0;
            req_i = pend;
            if (en != 0 && r == T + 1) begin mac_eof_i = 1'b1; mac_y_i = 18'h3ffff; end
            tick;
            mac_eof_i = 1'b0;
            n_tests++; if (busy_o !== 1'b0 || done_o !== '0 || y_o !== ey)
                begin n_fail++; $display("FAIL rnd_idle got=%b/%b/%h want=0/0/%h", busy_o, done_o, y_o, ey); end
        end
        req_i = '0;
        tick;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = '0; n_i = '0; s_i = '0;
        mac_y_i = '0; mac_i_i = '0; mac_eof_i = 1'b0;
        test_reset;
        test_single;
        test_fairness;
        test_starvation;
        test_reject;
        test_timeout;
        test_reset_midrun;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
